// File: rtl/mac_operand_feeder_pkg.sv
// Shared types for the MAC operand feeder: operand/accumulator widths,
// FSM state encoding and the FIFO entry record.
package mac_operand_feeder_pkg;

  localparam int OP_W  = 16;
  localparam int ACC_W = 36;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    HOLD
  } state_t;

  typedef struct packed {
    logic            last;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/mac_operand_fifo.sv
// Operand FIFO for the MAC feeder: wrap-around pointers, first-word
// fall-through read port, push refused whenever the FIFO is full.
module mac_operand_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic             doPush;
  logic             doPop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)
        count <= count + 1'b1;
      else if (!doPush && doPop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Streams buffered operand pairs into an external MAC, clearing it before
// each vector and capturing the dot product once the pipeline has drained.
module mac_operand_feeder
  import mac_operand_feeder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAC_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic [OP_W-1:0]  mac_a,
  output logic [OP_W-1:0]  mac_b,
  output logic             mac_clr_n,
  input  logic [ACC_W-1:0] mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [CNT_W-1:0] res_count,
  output logic             busy
);

  localparam int DRAIN_W = $clog2(MAC_LAT + 2);

  state_t             state;
  state_t             nextState;
  entry_t             pushEntry;
  entry_t             headEntry;
  logic [ENTRY_W-1:0] headBits;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               pop;
  logic [CNT_W-1:0]   pairCount;
  logic [DRAIN_W-1:0] drainCount;
  logic               drainDone;

  assign pushEntry = '{last: in_last, a: in_a, b: in_b};
  assign headEntry = entry_t'(headBits);
  assign in_ready  = !fifoFull;
  assign drainDone = (drainCount == DRAIN_W'(MAC_LAT));
  assign res_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  mac_operand_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (in_valid),
    .pushData (pushEntry),
    .pop      (pop),
    .popData  (headBits),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Pops happen only in STREAM, so nothing leaves the FIFO from DRAIN until IDLE.
  always_comb begin
    nextState = state;
    pop       = 1'b0;
    case (state)
      IDLE:   if (!fifoEmpty) nextState = CLEAR;
      CLEAR:  nextState = STREAM;
      STREAM: begin
        if (!fifoEmpty) begin
          pop = 1'b1;
          if (headEntry.last) nextState = DRAIN;
        end
      end
      DRAIN:  if (drainDone) nextState = HOLD;
      HOLD:   if (res_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Registered MAC drive: clear is low exactly while in CLEAR; an empty
  // FIFO in STREAM yields zero operands, a bubble that adds nothing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mac_a      <= '0;
      mac_b      <= '0;
      mac_clr_n  <= 1'b0;
      pairCount  <= '0;
      drainCount <= '0;
      res_data   <= '0;
      res_count  <= '0;
    end else begin
      mac_clr_n <= (nextState != CLEAR);
      mac_a     <= pop ? headEntry.a : '0;
      mac_b     <= pop ? headEntry.b : '0;

      if (state == CLEAR)
        pairCount <= '0;
      else if (pop && (pairCount != '1))
        pairCount <= pairCount + 1'b1;

      if (state == DRAIN) drainCount <= drainCount + 1'b1;
      else                drainCount <= '0;

      // Last DRAIN cycle: the final product has reached mac_out.
      if ((state == DRAIN) && drainDone) begin
        res_data  <= mac_out;
        res_count <= pairCount;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder with a behavioural MAC model
// and a result scoreboard.
module tb_mac_operand_feeder;

  localparam int DEPTH   = 4;
  localparam int MAC_LAT = 1;
  localparam int CNT_W   = 8;

  typedef struct {
    logic [35:0] data;
    logic [7:0]  count;
  } exp_t;

  typedef struct {
    int          n;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [15:0] a1;
    logic [15:0] b1;
    logic [35:0] expData;
    logic [7:0]  expCount;
  } vec_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             in_last;
  logic [15:0]      mac_a;
  logic [15:0]      mac_b;
  logic             mac_clr_n;
  logic [35:0]      mac_out;
  logic             res_valid;
  logic             res_ready;
  logic [35:0]      res_data;
  logic [CNT_W-1:0] res_count;
  logic             busy;

  int          errors;
  int          checks;
  int          clrCount;
  int          clrBase;
  logic        trackOps;
  logic [31:0] opLog[$];
  exp_t        expQ[$];
  exp_t        monExp;
  exp_t        tmpExp;
  vec_t        vecs[6];
  vec_t        tmpVec;
  logic [35:0] accPipe[MAC_LAT];
  logic [15:0] bpA[6];
  logic [15:0] bpB[6];
  logic        bpLast[6];
  logic        found;
  logic        ok;
  int          idx;
  int          accepted;
  int          unstable;
  int          streamed;
  int          nzCount;
  int          firstIdx;
  int          secondIdx;
  logic [31:0] nz0;
  logic [31:0] nz1;

  mac_operand_feeder #(
    .DEPTH   (DEPTH),
    .MAC_LAT (MAC_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clr_n (mac_clr_n),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_count (res_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: accumulate on each edge, cleared by mac_clr_n.
  always @(posedge clk) begin
    if (!mac_clr_n) accPipe[0] <= '0;
    else            accPipe[0] <= accPipe[0] + 36'(mac_a) * 36'(mac_b);
    for (int i = 1; i < MAC_LAT; i++) accPipe[i] <= accPipe[i-1];
  end
  assign mac_out = accPipe[MAC_LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard compare at every completed result handshake.
  always @(negedge clk) begin
    if (reset === 1'b1 && res_valid && res_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got %0d expected none", res_data);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("res_data", res_data, monExp.data);
        checkOutput("res_count", res_count, monExp.count);
      end
    end
    if (reset === 1'b1 && !mac_clr_n) clrCount++;
    if (trackOps) opLog.push_back({mac_a, mac_b});
  end

  task automatic pushPair(input logic [15:0] a, input logic [15:0] b, input logic last);
    logic accepted1;
    accepted1 = 1'b0;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_last   = last;
    for (int c = 0; c < 200 && !accepted1; c++) begin
      @(negedge clk);
      accepted1 = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!accepted1) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout: got in_ready=0 expected 1");
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    e.data  = v.expData;
    e.count = v.expCount;
    if (v.n == 2) begin
      pushPair(v.a0, v.b0, 1'b0);
      expQ.push_back(e);
      pushPair(v.a1, v.b1, 1'b1);
    end else begin
      expQ.push_back(e);
      pushPair(v.a0, v.b0, 1'b1);
    end
  endtask

  task automatic waitResults(input int budget);
    int i;
    i = 0;
    while (expQ.size() != 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL result_timeout: got %0d pending expected 0", expQ.size());
      expQ.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    errors++;
    checks++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors = 0; checks = 0; clrCount = 0; trackOps = 1'b0;
    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    res_ready = 1'b0;

    vecs[0] = '{2, 16'd12, 16'd20, 16'd11, 16'd5, 36'd295, 8'd2};
    vecs[1] = '{2, 16'd1, 16'd1, 16'd2, 16'd2, 36'd5, 8'd2};
    vecs[2] = '{1, 16'd65535, 16'd65535, 16'd0, 16'd0, 36'd4294836225, 8'd1};
    vecs[3] = '{2, 16'd0, 16'd0, 16'd0, 16'd0, 36'd0, 8'd2};
    vecs[4] = '{2, 16'd65535, 16'd65535, 16'd65535, 16'd65535, 36'd8589672450, 8'd2};
    vecs[5] = '{1, 16'd100, 16'd3, 16'd0, 16'd0, 36'd300, 8'd1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mac_a", mac_a, 0);
    checkOutput("rst_mac_b", mac_b, 0);
    checkOutput("rst_mac_clr_n", mac_clr_n, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_res_count", res_count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Table-driven single vectors, each preceded by exactly one clear.
    for (int i = 0; i < 6; i++) begin
      clrBase = clrCount;
      applyStimulus(vecs[i]);
      waitResults(100);
      checkOutput("clr_pulses", 64'(clrCount - clrBase), 1);
    end

    // Bubbles: the gap between pairs must reach the MAC as zero operands.
    opLog.delete();
    trackOps = 1'b1;
    pushPair(16'd3, 16'd4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    tmpExp = '{36'd16, 8'd2};
    expQ.push_back(tmpExp);
    pushPair(16'd2, 16'd2, 1'b1);
    waitResults(100);
    trackOps = 1'b0;
    nzCount = 0; firstIdx = 0; secondIdx = 0; nz0 = '0; nz1 = '0;
    foreach (opLog[k]) begin
      if (opLog[k] != 32'd0) begin
        if (nzCount == 0) begin firstIdx = k; nz0 = opLog[k]; end
        else if (nzCount == 1) begin secondIdx = k; nz1 = opLog[k]; end
        nzCount++;
      end
    end
    checkOutput("bubble_nonzero_ops", nzCount, 2);
    checkOutput("bubble_op0", nz0, {16'd3, 16'd4});
    checkOutput("bubble_op1", nz1, {16'd2, 16'd2});
    checkOutput("bubble_gap_seen", 64'((secondIdx - firstIdx - 1) >= 1), 1);

    // Backpressure: result held while FIFO fills to DEPTH, no streaming.
    bpA = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd9, 16'd11};
    bpB = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12};
    bpLast = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    res_ready = 1'b0;
    tmpVec = '{1, 16'd5, 16'd6, 16'd0, 16'd0, 36'd30, 8'd1};
    applyStimulus(tmpVec);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      found = res_valid;
    end
    checkOutput("bp_hold_reached", found, 1);
    @(posedge clk);
    #1;
    tmpExp = '{36'd100, 8'd4};
    expQ.push_back(tmpExp);
    tmpExp = '{36'd222, 8'd2};
    expQ.push_back(tmpExp);
    clrBase = clrCount;
    idx = 0; accepted = 0; unstable = 0; streamed = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 6) begin
        in_valid = 1'b1; in_a = bpA[idx]; in_b = bpB[idx]; in_last = bpLast[idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (res_data != 36'd30 || res_count != 8'd1 || !res_valid) unstable++;
      if (mac_a != 16'd0 || mac_b != 16'd0) streamed++;
      ok = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (ok) begin idx++; accepted++; end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    checkOutput("bp_accepted", accepted, DEPTH);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_busy", busy, 1);
    checkOutput("bp_unstable_cycles", unstable, 0);
    checkOutput("bp_streamed_cycles", streamed, 0);
    checkOutput("bp_no_clear", 64'(clrCount - clrBase), 0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    for (int k = idx; k < 6; k++) pushPair(bpA[k], bpB[k], bpLast[k]);
    waitResults(200);
    checkOutput("bp_clear_after_accept", 64'(clrCount - clrBase), 2);

    // Back-to-back vectors queued together, one clear each.
    clrBase = clrCount;
    pushPair(16'd1, 16'd1, 1'b0);
    tmpExp = '{36'd5, 8'd2};
    expQ.push_back(tmpExp);
    pushPair(16'd2, 16'd2, 1'b1);
    tmpExp = '{36'd4294836225, 8'd1};
    expQ.push_back(tmpExp);
    pushPair(16'd65535, 16'd65535, 1'b1);
    waitResults(100);
    checkOutput("b2b_clr_pulses", 64'(clrCount - clrBase), 2);

    // Pair counter saturates at its maximum.
    tmpExp = '{36'd257, 8'd255};
    for (int k = 0; k < 257; k++) begin
      if (k == 256) expQ.push_back(tmpExp);
      pushPair(16'd1, 16'd1, k == 256);
    end
    waitResults(100);

    // Reset during STREAM discards the partial vector.
    pushPair(16'd1, 16'd1, 1'b0);
    pushPair(16'd2, 16'd2, 1'b0);
    pushPair(16'd3, 16'd3, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = (mac_a != 16'd0);
    end
    checkOutput("mid_stream_reached", found, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_mac_a", mac_a, 0);
    checkOutput("mid_rst_mac_b", mac_b, 0);
    checkOutput("mid_rst_mac_clr_n", mac_clr_n, 0);
    checkOutput("mid_rst_res_valid", res_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_res_data", res_data, 0);
    checkOutput("mid_rst_res_count", res_count, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    tmpVec = '{1, 16'd7, 16'd7, 16'd0, 16'd0, 36'd49, 8'd1};
    applyStimulus(tmpVec);
    waitResults(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
